rx_unstripe_packer: RTL and testbench

Receive-path stage directly downstream of the lane data-handling block. Takes the per-lane striped symbols (16 lane slices of PIPEWIDTH bits, lanes 0..N-1 active, slices packed from bit 0) and restores the original byte order across the active lanes. Buffers the bytes in a circular byte FIFO and delivers fixed-width words to the link-layer framer over a valid/ready handshake.

---
 rtl/rx_mac_pkg.sv | 34 +++
 rtl/rx_unstripe_mux.sv | 52 +++++
 rtl/rx_unstripe_packer.sv | 136 +++++++++++++
 tb/tb_rx_unstripe_packer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_mac_pkg.sv
// Shared receive-path definitions: legal lane geometries and the per-beat byte count.
package rx_mac_pkg;

    localparam int MAX_BEAT_BYTES = 64;
    localparam int MAX_LANES      = 16;

    localparam logic [5:0] PW_8  = 6'd8;
    localparam logic [5:0] PW_16 = 6'd16;
    localparam logic [5:0] PW_32 = 6'd32;

    localparam logic [4:0] LANES_1  = 5'd1;
    localparam logic [4:0] LANES_2  = 5'd2;
    localparam logic [4:0] LANES_4  = 5'd4;
    localparam logic [4:0] LANES_8  = 5'd8;
    localparam logic [4:0] LANES_16 = 5'd16;

    // Bytes carried by one beat; 0 flags an illegal width/lane combination.
    function automatic logic [6:0] beat_bytes(input logic [5:0] pipewidth, input logic [4:0] lanes);
        logic [6:0] lane_bytes;
        logic [6:0] total;
        case (pipewidth)
            PW_8:    lane_bytes = 7'd1;
            PW_16:   lane_bytes = 7'd2;
            PW_32:   lane_bytes = 7'd4;
            default: lane_bytes = 7'd0;
        endcase
        case (lanes)
            LANES_1, LANES_2, LANES_4, LANES_8, LANES_16: total = 7'(lanes) * lane_bytes;
            default:                                      total = 7'd0;
        endcase
        return total;
    endfunction

endpackage

// File: rtl/rx_unstripe_mux.sv
// Reorders per-lane striped slices into one byte stream: index = byte_in_lane * lanes + lane.
module rx_unstripe_mux
    import rx_mac_pkg::*;
(
    input  logic [511:0]                striped_data,
    input  logic [63:0]                 striped_k,
    input  logic [5:0]                  pipewidth,
    input  logic [4:0]                  lanes,
    output logic [8*MAX_BEAT_BYTES-1:0] stream_data,
    output logic [MAX_BEAT_BYTES-1:0]   stream_k
);

    logic [2:0] lane_bytes;
    logic [2:0] lanes_log2;
    logic [3:0] lane_mask;

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
        lane_bytes = '0;
        lanes_log2 = '0;
        lane_mask  = '0;
        case (pipewidth)
            PW_8:    lane_bytes = 3'd1;
            PW_16:   lane_bytes = 3'd2;
            PW_32:   lane_bytes = 3'd4;
            default: lane_bytes = 3'd0;
        endcase
        case (lanes)
            LANES_2:  begin lanes_log2 = 3'd1; lane_mask = 4'h1; end
            LANES_4:  begin lanes_log2 = 3'd2; lane_mask = 4'h3; end
            LANES_8:  begin lanes_log2 = 3'd3; lane_mask = 4'h7; end
            LANES_16: begin lanes_log2 = 3'd4; lane_mask = 4'hF; end
            default:  begin lanes_log2 = 3'd0; lane_mask = 4'h0; end
        endcase
    end

    always_comb begin
        stream_data = '0;
        stream_k    = '0;
        for (int s = 0; s < MAX_BEAT_BYTES; s++) begin
            int lane_idx;
            int byte_idx;
            lane_idx = s & int'(lane_mask);
            byte_idx = s >> lanes_log2;
            if (byte_idx < int'(lane_bytes)) begin
                stream_data[8*s +: 8] = striped_data[9'(lane_idx * int'(pipewidth) + 8 * byte_idx) +: 8];
                stream_k[s]           = striped_k[6'(lane_idx * int'(lane_bytes) + byte_idx)];
            end
        end
    end

endmodule

// File: rtl/rx_unstripe_packer.sv
// Unstripes lane beats into a circular byte FIFO and emits OUT_BYTES-wide words on valid/ready.
// Optional residual-word flush (FLUSH, outByteEn) is enabled by defining RX_UNSTRIPE_FLUSH_EN.
module rx_unstripe_packer
    import rx_mac_pkg::*;
#(
    parameter int OUT_BYTES   = 32,
    parameter int DEPTH_BYTES = 128
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic [511:0]           stripedData,
    input  logic [63:0]            stripedDataK,
    input  logic [5:0]             PIPEWIDTH,
    input  logic [4:0]             LANESNUMBER,
    input  logic                   inValid,
    output logic [8*OUT_BYTES-1:0] outData,
    output logic [OUT_BYTES-1:0]   outDataK,
    output logic                   outValid,
    input  logic                   outReady,
    output logic                   overflow,
    output logic                   cfgError
`ifdef RX_UNSTRIPE_FLUSH_EN
    ,
    input  logic                   FLUSH,
    output logic [OUT_BYTES-1:0]   outByteEn
`endif
);

    localparam int PTR_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [7:0]                fifo_data_q [DEPTH_BYTES];
    logic                      fifo_k_q    [DEPTH_BYTES];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      overflow_q, overflow_d, cfg_error_q, cfg_error_d;

    logic [8*MAX_BEAT_BYTES-1:0] stream_data;
    logic [MAX_BEAT_BYTES-1:0]   stream_k;
    logic [6:0]                  beat_n;
    logic [SUM_W-1:0]            level_after;
    logic [CNT_W-1:0]            pop_bytes;
    logic                        full_word, out_valid, pop, push, beat_fits;
    logic [OUT_BYTES-1:0]        byte_en;

    rx_unstripe_mux u_mux (
        .striped_data (stripedData),
        .striped_k    (stripedDataK),
        .pipewidth    (PIPEWIDTH),
        .lanes        (LANESNUMBER),
        .stream_data  (stream_data),
        .stream_k     (stream_k)
    );

    always_comb begin
        beat_n    = beat_bytes(PIPEWIDTH, LANESNUMBER);
        full_word = count_q >= CNT_W'(OUT_BYTES);
`ifdef RX_UNSTRIPE_FLUSH_EN
        out_valid = full_word || (FLUSH && count_q != '0);
`else
        out_valid = full_word;
`endif
        pop       = out_valid && outReady;
        pop_bytes = '0;
        if (pop) begin
            pop_bytes = full_word ? CNT_W'(OUT_BYTES) : count_q;
        end
        // Space is judged after this cycle's pop so a full FIFO can still stream.
        level_after = SUM_W'(count_q) - SUM_W'(pop_bytes) + SUM_W'(beat_n);
        beat_fits   = level_after <= SUM_W'(DEPTH_BYTES);
        push        = inValid && beat_n != '0 && beat_fits;

        count_d     = count_q - pop_bytes + (push ? CNT_W'(beat_n) : '0);
        wr_ptr_d    = wr_ptr_q + (push ? PTR_W'(beat_n) : '0);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_bytes);
        overflow_d  = overflow_q  || (inValid && beat_n != '0 && !beat_fits);
        cfg_error_d = cfg_error_q || (inValid && beat_n == '0);
    end

`ifdef RX_UNSTRIPE_FLUSH_EN
    always_comb begin
        for (int b = 0; b < OUT_BYTES; b++) begin
            byte_en[b] = out_valid && (full_word || CNT_W'(b) < count_q);
        end
    end
    assign outByteEn = byte_en;
`else
    assign byte_en = {OUT_BYTES{out_valid}};
`endif

    always_comb begin
        outData  = '0;
        outDataK = '0;
        for (int b = 0; b < OUT_BYTES; b++) begin
            if (byte_en[b]) begin
                outData[8*b +: 8] = fifo_data_q[rd_ptr_q + PTR_W'(b)];
                outDataK[b]       = fifo_k_q[rd_ptr_q + PTR_W'(b)];
            end
        end
    end

    assign outValid = out_valid;
    assign overflow = overflow_q;
    assign cfgError = cfg_error_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates every read so stale bytes never appear.
    always_ff @(posedge CLK) begin
        if (push) begin
            for (int i = 0; i < MAX_BEAT_BYTES; i++) begin
                if (7'(i) < beat_n) begin
                    fifo_data_q[wr_ptr_q + PTR_W'(i)] <= stream_data[8*i +: 8];
                    fifo_k_q[wr_ptr_q + PTR_W'(i)]    <= stream_k[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_unstripe_packer.sv
// Directed, table-driven bench for rx_unstripe_packer (OUT_BYTES=32, DEPTH_BYTES=128).
module tb_rx_unstripe_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] sd;
    logic [63:0]  sk;
    logic [5:0]   pw;
    logic [4:0]   ln;
    logic         in_valid, out_ready;
    logic [255:0] out_data;
    logic [31:0]  out_k;
    logic         out_valid, overflow, cfg_err;
`ifdef RX_UNSTRIPE_FLUSH_EN
    logic         flush;
    logic [31:0]  out_be;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rx_unstripe_packer #(.OUT_BYTES(32), .DEPTH_BYTES(128)) dut (
        .CLK          (clk),
        .RESETn       (rst_n),
        .stripedData  (sd),
        .stripedDataK (sk),
        .PIPEWIDTH    (pw),
        .LANESNUMBER  (ln),
        .inValid      (in_valid),
        .outData      (out_data),
        .outDataK     (out_k),
        .outValid     (out_valid),
        .outReady     (out_ready),
        .overflow     (overflow),
        .cfgError     (cfg_err)
`ifdef RX_UNSTRIPE_FLUSH_EN
        ,
        .FLUSH        (flush),
        .outByteEn    (out_be)
`endif
    );

    typedef struct {
        logic [5:0]  pw;
        logic [4:0]  ln;
        int          beats;
        logic        exp_valid;
        logic [31:0] exp_lo;
        logic [7:0]  exp_b31;
        logic [31:0] exp_k;
        logic        exp_cfg;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Lane L byte k carries {L,k}; K set on lane 1 byte 0 and on lane 0 byte 1.
    task automatic push_pattern(input logic [5:0] p, input logic [4:0] l);
        int bpl;
        bpl = int'(p) / 8;
        sd = '0;
        sk = '0;
        for (int lane = 0; lane < 16; lane++) begin
            for (int k = 0; k < bpl; k++) begin
                sd[lane*int'(p) + 8*k +: 8] = {lane[3:0], k[3:0]};
            end
        end
        sk[bpl] = 1'b1;
        if (bpl >= 2) sk[1] = 1'b1;
        pw = p;
        ln = l;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Lays out stimulus so the unstriped stream reads base, base+1, base+2, ...
    task automatic set_seq(input logic [5:0] p, input logic [4:0] l, input int base);
        int bpl;
        bpl = int'(p) / 8;
        sd = '0;
        sk = '0;
        for (int k = 0; k < bpl; k++) begin
            for (int lane = 0; lane < int'(l); lane++) begin
                sd[lane*int'(p) + 8*k +: 8] = 8'(base + k*int'(l) + lane);
            end
        end
        pw = p;
        ln = l;
    endtask

    task automatic push_seq(input logic [5:0] p, input logic [4:0] l, input int base);
        set_seq(p, l, base);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [255:0] seq_word(input int base);
        logic [255:0] w;
        for (int i = 0; i < 32; i++) w[8*i +: 8] = 8'(base + i);
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; sd = '0; sk = '0; pw = 6'd8; ln = 5'd16;
        in_valid = 1'b0; out_ready = 1'b0;
`ifdef RX_UNSTRIPE_FLUSH_EN
        flush = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;

        check("reset_valid", out_valid, 1'b0);
        check("reset_data", out_data, '0);
        check("reset_k", out_k, '0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_cfg", cfg_err, 1'b0);
`ifdef RX_UNSTRIPE_FLUSH_EN
        check("reset_byte_en", out_be, '0);
`endif

        // x16 byte-wide lanes, 4 beats -> two words 0x00..0x1F and 0x20..0x3F.
        for (int b = 0; b < 4; b++) push_seq(6'd8, 5'd16, 16*b);
        check("idle_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        check("idle_word0", out_data, seq_word(0));
        check("idle_k0", out_k, '0);
        tick();
        check("idle_word1", out_data, seq_word(32));
        tick();
        out_ready = 1'b0;
        check("idle_drained", out_valid, 1'b0);

        vecs[0] = '{6'd8,  5'd16, 2,  1'b1, 32'h30201000, 8'hF0, 32'h00020002, 1'b0};
        vecs[1] = '{6'd32, 5'd4,  2,  1'b1, 32'h30201000, 8'h33, 32'h00120012, 1'b0};
        vecs[2] = '{6'd16, 5'd8,  2,  1'b1, 32'h30201000, 8'h71, 32'h01020102, 1'b0};
        vecs[3] = '{6'd32, 5'd16, 1,  1'b1, 32'h30201000, 8'hF1, 32'h00010002, 1'b0};
        vecs[4] = '{6'd8,  5'd1,  32, 1'b1, 32'h00000000, 8'h00, 32'h00000000, 1'b0};
        vecs[5] = '{6'd16, 5'd2,  8,  1'b1, 32'h11011000, 8'h11, 32'h66666666, 1'b0};
        vecs[6] = '{6'd8,  5'd3,  1,  1'b0, 32'h00000000, 8'h00, 32'h00000000, 1'b1};
        vecs[7] = '{6'd24, 5'd4,  1,  1'b0, 32'h00000000, 8'h00, 32'h00000000, 1'b1};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int b = 0; b < vecs[v].beats; b++) push_pattern(vecs[v].pw, vecs[v].ln);
            check($sformatf("vec%0d_valid", v), out_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d_lo", v), out_data[31:0], vecs[v].exp_lo);
            check($sformatf("vec%0d_b31", v), out_data[255:248], vecs[v].exp_b31);
            check($sformatf("vec%0d_k", v), out_k, vecs[v].exp_k);
            check($sformatf("vec%0d_cfg", v), cfg_err, vecs[v].exp_cfg);
            check($sformatf("vec%0d_ovf", v), overflow, 1'b0);
        end

        // Backpressure: two 64-byte beats fill the FIFO, the third is dropped whole.
        do_reset();
        push_seq(6'd32, 5'd16, 0);
        push_seq(6'd32, 5'd16, 64);
        check("ovf_before", overflow, 1'b0);
        push_seq(6'd32, 5'd16, 128);
        check("ovf_set", overflow, 1'b1);
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            check($sformatf("ovf_word%0d", w), out_data, seq_word(32*w));
            tick();
        end
        out_ready = 1'b0;
        check("ovf_drained", out_valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // count=96, then a 64-byte beat during a pop: fills to exactly 128 across the wrap.
        do_reset();
        push_seq(6'd32, 5'd16, 0);
        push_seq(6'd32, 5'd8, 64);
        set_seq(6'd32, 5'd16, 96);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("wrap_word0", out_data, seq_word(0));
        tick();
        in_valid = 1'b0;
        check("wrap_no_ovf", overflow, 1'b0);
        for (int w = 1; w < 5; w++) begin
            check($sformatf("wrap_word%0d", w), out_data, seq_word(32*w));
            tick();
        end
        out_ready = 1'b0;
        check("wrap_drained", out_valid, 1'b0);

        // An illegal beat between two legal halves leaves the word intact.
        do_reset();
        push_seq(6'd16, 5'd8, 0);
        push_seq(6'd8, 5'd3, 85);
        check("cfg_set", cfg_err, 1'b1);
        check("cfg_count_kept", out_valid, 1'b0);
        push_seq(6'd16, 5'd8, 16);
        check("cfg_valid", out_valid, 1'b1);
        check("cfg_word", out_data, seq_word(0));

        // Reset mid-stream beats a same-cycle beat.
        set_seq(6'd32, 5'd16, 200);
        in_valid = 1'b1;
        rst_n    = 1'b0;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_k", out_k, '0);
        check("rst_cfg", cfg_err, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        tick();
        check("rst_beat_gone", out_valid, 1'b0);

`ifdef RX_UNSTRIPE_FLUSH_EN
        begin
            logic [255:0] exp_w;
            exp_w = '0;
            for (int i = 0; i < 5; i++) begin
                push_seq(6'd8, 5'd1, 160 + i);
                exp_w[8*i +: 8] = 8'(160 + i);
            end
            check("flush_idle", out_valid, 1'b0);
            flush = 1'b1;
            check("flush_valid", out_valid, 1'b1);
            check("flush_be", out_be, 32'h0000001F);
            check("flush_data", out_data, exp_w);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("flush_empty", out_valid, 1'b0);
            flush = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
